// File: rtl/gather_input_stage_mvc.sv
// ---------------------------------------------------------------------------
// gather_input_stage_mvc
//
// Multi-virtual-channel input stage of the gather router. Each input VC owns
// a first-word-fall-through buffer and a small route / VC-allocation state
// machine. A round-robin switch arbiter presents one flit per cycle toward
// the crossbar; a flit leaving a buffer returns one credit upstream.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   valid_i       upstream flit valid (no backpressure, credits guard it)
//   vc_i, data_i  target VC and flit payload of the incoming flit
//   credit_o      one-cycle pulse per VC whenever a flit leaves its buffer
//   rt_sid_o      stream id of each VC's head flit, toward the route table
//   rt_cand_i     candidate output channels per VC returned by the table
//   req_o         per-VC allocation request vectors
//   gnt_valid_i   allocator grant strobe, with gnt_vc_i / gnt_out_i
//   rel_o         one-hot output release when a tail/single flit departs
//   valid_o       flit available (never depends on ready_i)
//   data_o, vc_o  presented flit and its source VC
//   sel_xb_o      one-hot crossbar select for the presented flit
//   ready_i       downstream accept
//   err_o         sticky overflow / protocol error flag
// ---------------------------------------------------------------------------
module gather_input_stage_mvc #(
    parameter int DW        = 32,
    parameter int VN        = 2,
    parameter int CN        = 5,
    parameter int DEPTH_LOG = 2,
    parameter int SID_H     = 29,
    parameter int SID_L     = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    input  logic [$clog2(VN)-1:0]         vc_i,
    input  logic [DW-1:0]                 data_i,
    output logic [VN-1:0]                 credit_o,
    output logic [VN*(SID_H-SID_L+1)-1:0] rt_sid_o,
    input  logic [VN*CN-1:0]              rt_cand_i,
    output logic [VN*CN-1:0]              req_o,
    input  logic                          gnt_valid_i,
    input  logic [$clog2(VN)-1:0]         gnt_vc_i,
    input  logic [CN-1:0]                 gnt_out_i,
    output logic [CN-1:0]                 rel_o,
    output logic                          valid_o,
    output logic [DW-1:0]                 data_o,
    output logic [$clog2(VN)-1:0]         vc_o,
    output logic [CN-1:0]                 sel_xb_o,
    input  logic                          ready_i,
    output logic                          err_o
);
    localparam int VW    = $clog2(VN);
    localparam int VW1   = VW + 1;
    localparam int SW    = SID_H - SID_L + 1;
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int CW    = DEPTH_LOG + 1;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_REQ    = 2'd1,
        VC_ACTIVE = 2'd2
    } vc_state_t;

    vc_state_t            state_q  [VN];
    vc_state_t            state_d  [VN];
    logic [CN-1:0]        cand_q   [VN];
    logic [CN-1:0]        cand_d   [VN];
    logic [CN-1:0]        osel_q   [VN];
    logic [CN-1:0]        osel_d   [VN];
    logic [DW-1:0]        mem      [VN][DEPTH];
    logic [DW-1:0]        head     [VN];
    logic [DEPTH_LOG-1:0] wr_ptr_q [VN];
    logic [DEPTH_LOG-1:0] rd_ptr_q [VN];
    logic [CW-1:0]        cnt_q    [VN];

    logic [VN-1:0] empty, full, wr_en, wr_ok, pop, eligible;
    logic [VW-1:0] rr_ptr_q, rr_sel, chosen, lock_vc_q;
    logic [VW:0]   rr_idx;
    logic          rr_found, locked_q, fire;
    logic          grant_hit, grant_err, overflow, discard_err, err_q;

    // Buffer status and the head flit of every VC. The stream id toward the
    // route table is forced to zero while a buffer is empty so stale storage
    // never leaks out.
    always_comb begin
        for (int v = 0; v < VN; v++) begin
            head[v]              = mem[v][rd_ptr_q[v]];
            empty[v]             = (cnt_q[v] == '0);
            full[v]              = (cnt_q[v] == CW'(DEPTH));
            wr_en[v]             = valid_i && (vc_i == VW'(v));
            eligible[v]          = (state_q[v] == VC_ACTIVE) && !empty[v];
            rt_sid_o[v*SW +: SW] = empty[v] ? '0 : head[v][SID_H:SID_L];
        end
    end

    // A write into a full buffer is only legal when the same buffer is being
    // popped in that cycle; otherwise the flit is dropped and flagged.
    always_comb begin
        for (int v = 0; v < VN; v++) begin
            wr_ok[v] = wr_en[v] && (!full[v] || pop[v]);
        end
        overflow = |(wr_en & ~wr_ok);
    end

    // Round-robin switch arbiter. A presented flit that was not accepted
    // locks the choice so the output stays stable until it fires.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < VN; i++) begin
            rr_idx = {1'b0, rr_ptr_q} + VW1'(i);
            if (rr_idx >= VW1'(VN)) begin
                rr_idx = rr_idx - VW1'(VN);
            end
            if (!rr_found && eligible[rr_idx[VW-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx[VW-1:0];
            end
        end
        chosen   = locked_q ? lock_vc_q : rr_sel;
        valid_o  = |eligible;
        fire     = valid_o && ready_i;
        data_o   = valid_o ? head[chosen] : '0;
        vc_o     = valid_o ? chosen : '0;
        sel_xb_o = valid_o ? osel_q[chosen] : '0;
    end

    // Per-VC route / allocation state machines. A buffer leading with a body
    // or tail flit while idle is a protocol error: the flit is discarded and
    // its credit returned so the upstream credit count stays consistent.
    always_comb begin
        req_o       = '0;
        rel_o       = '0;
        pop         = '0;
        grant_hit   = 1'b0;
        discard_err = 1'b0;
        for (int v = 0; v < VN; v++) begin
            state_d[v] = state_q[v];
            cand_d[v]  = cand_q[v];
            osel_d[v]  = osel_q[v];
            case (state_q[v])
                VC_IDLE: begin
                    if (!empty[v]) begin
                        if (head[v][DW-1]) begin
                            cand_d[v]  = rt_cand_i[v*CN +: CN];
                            state_d[v] = VC_REQ;
                        end else begin
                            pop[v]      = 1'b1;
                            discard_err = 1'b1;
                        end
                    end
                end
                VC_REQ: begin
                    req_o[v*CN +: CN] = cand_q[v];
                    if (gnt_valid_i && (gnt_vc_i == VW'(v))) begin
                        grant_hit  = 1'b1;
                        osel_d[v]  = gnt_out_i;
                        state_d[v] = VC_ACTIVE;
                    end
                end
                VC_ACTIVE: begin
                    if (fire && (chosen == VW'(v))) begin
                        pop[v] = 1'b1;
                        if (head[v][DW-2]) begin
                            rel_o      = osel_q[v];
                            state_d[v] = VC_IDLE;
                        end
                    end
                end
                default: state_d[v] = VC_IDLE;
            endcase
        end
        grant_err = gnt_valid_i && !grant_hit;
        credit_o  = pop;
    end

    // State, buffer pointers, arbiter pointer, lock and the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VN; v++) begin
                state_q[v]  <= VC_IDLE;
                cand_q[v]   <= '0;
                osel_q[v]   <= '0;
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            rr_ptr_q  <= '0;
            locked_q  <= 1'b0;
            lock_vc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int v = 0; v < VN; v++) begin
                state_q[v] <= state_d[v];
                cand_q[v]  <= cand_d[v];
                osel_q[v]  <= osel_d[v];
                if (wr_ok[v]) begin
                    wr_ptr_q[v] <= wr_ptr_q[v] + DEPTH_LOG'(1);
                end
                if (pop[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + DEPTH_LOG'(1);
                end
                cnt_q[v] <= cnt_q[v] + CW'(wr_ok[v]) - CW'(pop[v]);
            end
            if (fire) begin
                rr_ptr_q <= (chosen == VW'(VN - 1)) ? '0 : chosen + VW'(1);
                locked_q <= 1'b0;
            end else if (valid_o) begin
                locked_q  <= 1'b1;
                lock_vc_q <= chosen;
            end
            if (overflow || discard_err || grant_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Flit storage needs no reset; occupancy counters define what is valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VN; v++) begin
            if (wr_ok[v]) begin
                mem[v][wr_ptr_q[v]] <= data_i;
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_gather_input_stage_mvc.sv
// ---------------------------------------------------------------------------
// tb_gather_input_stage_mvc
//
// Directed bench for gather_input_stage_mvc. Expected output flits are queued
// when their packets are injected; a negedge monitor pops and compares every
// accepted output flit (data, source VC, crossbar select, release, credit).
// ---------------------------------------------------------------------------
module tb_gather_input_stage_mvc;
    localparam int DW        = 32;
    localparam int VN        = 2;
    localparam int CN        = 5;
    localparam int DEPTH_LOG = 2;
    localparam int SID_H     = 29;
    localparam int SID_L     = 24;
    localparam int VW        = 1;
    localparam int SW        = SID_H - SID_L + 1;

    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic [VW-1:0]      vc_i;
    logic [DW-1:0]      data_i;
    logic [VN-1:0]      credit_o;
    logic [VN*SW-1:0]   rt_sid_o;
    logic [VN*CN-1:0]   rt_cand_i;
    logic [VN*CN-1:0]   req_o;
    logic               gnt_valid_i;
    logic [VW-1:0]      gnt_vc_i;
    logic [CN-1:0]      gnt_out_i;
    logic [CN-1:0]      rel_o;
    logic               valid_o;
    logic [DW-1:0]      data_o;
    logic [VW-1:0]      vc_o;
    logic [CN-1:0]      sel_xb_o;
    logic               ready_i;
    logic               err_o;

    typedef struct {
        logic [DW-1:0] data;
        logic [VW-1:0] vc;
        logic [CN-1:0] sel;
        logic [CN-1:0] rel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   checks      = 0;
    int   errors      = 0;
    int   credit0_cnt = 0;
    int   credit1_cnt = 0;
    int   snap;

    gather_input_stage_mvc #(
        .DW(DW), .VN(VN), .CN(CN), .DEPTH_LOG(DEPTH_LOG),
        .SID_H(SID_H), .SID_L(SID_L)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .vc_i(vc_i), .data_i(data_i),
        .credit_o(credit_o), .rt_sid_o(rt_sid_o), .rt_cand_i(rt_cand_i),
        .req_o(req_o), .gnt_valid_i(gnt_valid_i), .gnt_vc_i(gnt_vc_i),
        .gnt_out_i(gnt_out_i), .rel_o(rel_o), .valid_o(valid_o),
        .data_o(data_o), .vc_o(vc_o), .sel_xb_o(sel_xb_o),
        .ready_i(ready_i), .err_o(err_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_flit(input logic [1:0] t, input logic [5:0] sid,
                                              input logic [23:0] pay);
        return {t, sid, pay};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle upstream write of a flit into a VC.
    task automatic applyStimulus(input logic [VW-1:0] vc, input logic [DW-1:0] flit);
        valid_i = 1'b1;
        vc_i    = vc;
        data_i  = flit;
        tick(1);
        valid_i = 1'b0;
        vc_i    = '0;
        data_i  = '0;
    endtask

    task automatic grant(input logic [VW-1:0] vc, input logic [CN-1:0] out);
        gnt_valid_i = 1'b1;
        gnt_vc_i    = vc;
        gnt_out_i   = out;
        tick(1);
        gnt_valid_i = 1'b0;
        gnt_vc_i    = '0;
        gnt_out_i   = '0;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [VW-1:0] v,
                            input logic [CN-1:0] s, input logic [CN-1:0] r);
        exp_t e;
        e.data = d;
        e.vc   = v;
        e.sel  = s;
        e.rel  = r;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_valid"},  64'(valid_o),  64'd0);
        checkOutput({tag, "_credit"}, 64'(credit_o), 64'd0);
        checkOutput({tag, "_req"},    64'(req_o),    64'd0);
        checkOutput({tag, "_rel"},    64'(rel_o),    64'd0);
        checkOutput({tag, "_sel"},    64'(sel_xb_o), 64'd0);
        checkOutput({tag, "_data"},   64'(data_o),   64'd0);
        checkOutput({tag, "_vc"},     64'(vc_o),     64'd0);
        checkOutput({tag, "_rt_sid"}, 64'(rt_sid_o), 64'd0);
        checkOutput({tag, "_err"},    64'(err_o),    64'd0);
    endtask

    // Monitor: every accepted flit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (credit_o[0]) credit0_cnt++;
            if (credit_o[1]) credit1_cnt++;
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL fire_unexpected actual=0x%0h required=no flit", data_o);
                end else begin
                    mon_exp = sb.pop_front();
                    checkOutput("fire_data",   64'(data_o),   64'(mon_exp.data));
                    checkOutput("fire_vc",     64'(vc_o),     64'(mon_exp.vc));
                    checkOutput("fire_sel",    64'(sel_xb_o), 64'(mon_exp.sel));
                    checkOutput("fire_rel",    64'(rel_o),    64'(mon_exp.rel));
                    checkOutput("fire_credit", 64'(credit_o), 64'(2'b01 << mon_exp.vc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        valid_i     = 1'b0;
        vc_i        = '0;
        data_i      = '0;
        rt_cand_i   = '0;
        gnt_valid_i = 1'b0;
        gnt_vc_i    = '0;
        gnt_out_i   = '0;
        ready_i     = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(1);

        // Single packet on VC0 routed to channel 2.
        $display("[TB] single packet on VC0");
        rt_cand_i = {5'b00000, 5'b00100};
        applyStimulus(1'b0, mk_flit(T_HEAD, 6'd5, 24'h000011));
        checkOutput("t1_rt_sid", 64'(rt_sid_o[5:0]), 64'd5);
        checkOutput("t1_req_latency", 64'(req_o), 64'd0);
        applyStimulus(1'b0, mk_flit(T_BODY, 6'd5, 24'h000012));
        applyStimulus(1'b0, mk_flit(T_BODY, 6'd5, 24'h000013));
        applyStimulus(1'b0, mk_flit(T_TAIL, 6'd5, 24'h000014));
        checkOutput("t1_req", 64'(req_o), 64'h004);
        checkOutput("t1_no_valid", 64'(valid_o), 64'd0);
        push_exp(mk_flit(T_HEAD, 6'd5, 24'h000011), 1'b0, 5'b00100, 5'b00000);
        push_exp(mk_flit(T_BODY, 6'd5, 24'h000012), 1'b0, 5'b00100, 5'b00000);
        push_exp(mk_flit(T_BODY, 6'd5, 24'h000013), 1'b0, 5'b00100, 5'b00000);
        push_exp(mk_flit(T_TAIL, 6'd5, 24'h000014), 1'b0, 5'b00100, 5'b00100);
        snap    = credit0_cnt;
        ready_i = 1'b1;
        grant(1'b0, 5'b00100);
        checkOutput("t1_req_dropped", 64'(req_o), 64'd0);
        wait_drain("t1_drain", 20);
        tick(2);
        checkOutput("t1_credits", 64'(credit0_cnt - snap), 64'd4);
        checkOutput("t1_idle", 64'(valid_o), 64'd0);

        // Two VCs active: backpressure hold, then alternating service.
        $display("[TB] two VCs with backpressure");
        ready_i   = 1'b0;
        rt_cand_i = {5'b00010, 5'b00001};
        applyStimulus(1'b0, mk_flit(T_HEAD, 6'd1, 24'h000021));
        applyStimulus(1'b0, mk_flit(T_BODY, 6'd1, 24'h000022));
        applyStimulus(1'b0, mk_flit(T_TAIL, 6'd1, 24'h000023));
        applyStimulus(1'b1, mk_flit(T_HEAD, 6'd2, 24'h000031));
        applyStimulus(1'b1, mk_flit(T_BODY, 6'd2, 24'h000032));
        applyStimulus(1'b1, mk_flit(T_TAIL, 6'd2, 24'h000033));
        checkOutput("t2_req_both", 64'(req_o), 64'h041);
        grant(1'b0, 5'b00001);
        grant(1'b1, 5'b00010);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_valid",  64'(valid_o),  64'd1);
            checkOutput("t2_hold_vc",     64'(vc_o),     64'd0);
            checkOutput("t2_hold_data",   64'(data_o),   64'(mk_flit(T_HEAD, 6'd1, 24'h000021)));
            checkOutput("t2_hold_credit", 64'(credit_o), 64'd0);
            tick(1);
        end
        push_exp(mk_flit(T_HEAD, 6'd1, 24'h000021), 1'b0, 5'b00001, 5'b00000);
        push_exp(mk_flit(T_HEAD, 6'd2, 24'h000031), 1'b1, 5'b00010, 5'b00000);
        push_exp(mk_flit(T_BODY, 6'd1, 24'h000022), 1'b0, 5'b00001, 5'b00000);
        push_exp(mk_flit(T_BODY, 6'd2, 24'h000032), 1'b1, 5'b00010, 5'b00000);
        push_exp(mk_flit(T_TAIL, 6'd1, 24'h000023), 1'b0, 5'b00001, 5'b00001);
        push_exp(mk_flit(T_TAIL, 6'd2, 24'h000033), 1'b1, 5'b00010, 5'b00010);
        ready_i = 1'b1;
        wait_drain("t2_drain", 30);
        tick(1);
        checkOutput("t2_err", 64'(err_o), 64'd0);

        // Overflow of VC1.
        $display("[TB] overflow on VC1");
        applyStimulus(1'b1, mk_flit(T_HEAD, 6'd3, 24'h000041));
        applyStimulus(1'b1, mk_flit(T_BODY, 6'd3, 24'h000042));
        applyStimulus(1'b1, mk_flit(T_BODY, 6'd3, 24'h000043));
        applyStimulus(1'b1, mk_flit(T_BODY, 6'd3, 24'h000044));
        checkOutput("t3_err_before", 64'(err_o), 64'd0);
        applyStimulus(1'b1, mk_flit(T_BODY, 6'd3, 24'h000045));
        checkOutput("t3_err_overflow", 64'(err_o), 64'd1);
        tick(3);
        checkOutput("t3_err_sticky", 64'(err_o), 64'd1);

        // Reset while VC0 is active with three flits buffered.
        $display("[TB] reset mid-packet");
        ready_i = 1'b0;
        applyStimulus(1'b0, mk_flit(T_HEAD, 6'd4, 24'h000051));
        applyStimulus(1'b0, mk_flit(T_BODY, 6'd4, 24'h000052));
        applyStimulus(1'b0, mk_flit(T_BODY, 6'd4, 24'h000053));
        grant(1'b0, 5'b00001);
        checkOutput("t4_active", 64'(valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("t4_reset");
        tick(2);
        rst = 1'b0;
        checkOutput("t4_empty_valid", 64'(valid_o), 64'd0);
        checkOutput("t4_empty_sid", 64'(rt_sid_o), 64'd0);
        applyStimulus(1'b0, mk_flit(T_HEAD, 6'd7, 24'h000061));
        checkOutput("t4_new_sid", 64'(rt_sid_o[5:0]), 64'd7);
        tick(1);
        checkOutput("t4_new_req", 64'(req_o), 64'h001);

        // Full VC0: write and pop in the same cycle is not an error.
        $display("[TB] full buffer write with pop");
        applyStimulus(1'b0, mk_flit(T_BODY, 6'd7, 24'h000062));
        applyStimulus(1'b0, mk_flit(T_BODY, 6'd7, 24'h000063));
        applyStimulus(1'b0, mk_flit(T_TAIL, 6'd7, 24'h000064));
        grant(1'b0, 5'b00001);
        push_exp(mk_flit(T_HEAD, 6'd7, 24'h000061), 1'b0, 5'b00001, 5'b00000);
        push_exp(mk_flit(T_BODY, 6'd7, 24'h000062), 1'b0, 5'b00001, 5'b00000);
        push_exp(mk_flit(T_BODY, 6'd7, 24'h000063), 1'b0, 5'b00001, 5'b00000);
        push_exp(mk_flit(T_TAIL, 6'd7, 24'h000064), 1'b0, 5'b00001, 5'b00001);
        ready_i = 1'b1;
        applyStimulus(1'b0, mk_flit(T_SINGLE, 6'd9, 24'h000071));
        checkOutput("t5_full_wr_pop_err", 64'(err_o), 64'd0);
        wait_drain("t5_drain", 20);
        tick(2);
        checkOutput("t5_single_req", 64'(req_o), 64'h001);
        push_exp(mk_flit(T_SINGLE, 6'd9, 24'h000071), 1'b0, 5'b00001, 5'b00001);
        grant(1'b0, 5'b00001);
        wait_drain("t5_single_drain", 10);
        checkOutput("t5_err", 64'(err_o), 64'd0);

        // Protocol errors: leading body flit, grant to an idle VC.
        $display("[TB] protocol errors");
        snap = credit1_cnt;
        applyStimulus(1'b1, mk_flit(T_BODY, 6'd0, 24'h000081));
        tick(3);
        checkOutput("t6_discard_credit", 64'(credit1_cnt - snap), 64'd1);
        checkOutput("t6_discard_err", 64'(err_o), 64'd1);
        checkOutput("t6_discard_req", 64'(req_o), 64'd0);
        checkOutput("t6_discard_valid", 64'(valid_o), 64'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("t6_err_cleared", 64'(err_o), 64'd0);
        grant(1'b0, 5'b00100);
        checkOutput("t6_grant_idle_err", 64'(err_o), 64'd1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
